// File: rtl/pattern_gen.sv
// Multi-mode video test-pattern generator: colour-bar grid, checkerboard, grey ramp, scrolling bars.
// Two-cycle pipeline from coordinate to colour; no backpressure, one pixel accepted every clock.
module pattern_gen #(
   parameter int X_W         = 11,
   parameter int Y_W         = 10,
   parameter int BPC         = 2,
   parameter int H_ACTIVE    = 800,
   parameter int V_ACTIVE    = 600,
   parameter int BAR_W       = 100,
   parameter int BAR_H       = 75,
   parameter int CHK_LOG2    = 5,
   parameter int GRAD_SHIFT  = 3,
   parameter int SCROLL_STEP = 4,
   parameter int FRAME_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [X_W-1:0]       x,
   input  logic [Y_W-1:0]       y,
   input  logic                 frame_start,
   input  logic [1:0]           mode,
   output logic [3*BPC-1:0]     color,
   output logic [1:0]           mode_active,
   output logic [FRAME_W-1:0]   frame_cnt
);

   localparam int CW       = 3 * BPC;
   localparam int GREY_MAX = (1 << BPC) - 1;

   localparam logic [1:0] MODE_GRID   = 2'd0;
   localparam logic [1:0] MODE_CHECK  = 2'd1;
   localparam logic [1:0] MODE_RAMP   = 2'd2;
   localparam logic [1:0] MODE_SCROLL = 2'd3;

   // Elaboration-time guards on parameter combinations the datapath relies on.
   if (BPC < 2 || BPC > 8) begin : g_bad_bpc
      $error("pattern_gen: BPC must be in 2..8");
   end
   if (8 * BAR_W < H_ACTIVE || 8 * BAR_H < V_ACTIVE) begin : g_bad_bar
      $error("pattern_gen: eight bars must cover the active area");
   end
   if (SCROLL_STEP <= 0 || SCROLL_STEP >= H_ACTIVE) begin : g_bad_step
      $error("pattern_gen: SCROLL_STEP must be in 1..H_ACTIVE-1");
   end
   if (CHK_LOG2 >= X_W || CHK_LOG2 >= Y_W) begin : g_bad_chk
      $error("pattern_gen: CHK_LOG2 exceeds coordinate width");
   end

   // Bar colour table, bit c selects channel c.
   function automatic logic [2:0] bar_bits(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_bits = 3'b000;
         3'd1:    bar_bits = 3'b001;
         3'd2:    bar_bits = 3'b010;
         3'd3:    bar_bits = 3'b100;
         3'd4:    bar_bits = 3'b011;
         3'd5:    bar_bits = 3'b101;
         3'd6:    bar_bits = 3'b110;
         default: bar_bits = 3'b111;
      endcase
   endfunction

   logic [X_W-1:0] offset;

   logic [X_W:0]   off_sum;
   logic [X_W-1:0] off_next;
   logic [X_W-1:0] off_eff;
   logic [1:0]     mode_eff;
   logic [X_W:0]   x_sum;
   logic [X_W:0]   x_eff;
   logic [X_W-1:0] x_shr;
   logic [2:0]     bx_d;
   logic [2:0]     by_d;
   logic           blank_d;
   logic           chk_d;
   logic [BPC-1:0] grey_d;

   // A frame_start pixel already belongs to the new frame, so it sees the new mode and offset.
   always_comb begin
      off_sum  = {1'b0, offset} + (X_W+1)'(SCROLL_STEP);
      off_next = off_sum[X_W-1:0];
      if (off_sum >= (X_W+1)'(H_ACTIVE))
         off_next = X_W'(off_sum - (X_W+1)'(H_ACTIVE));
      mode_eff = frame_start ? mode : mode_active;
      off_eff  = (frame_start && mode == MODE_SCROLL) ? off_next : offset;
   end

   always_comb begin
      x_sum = {1'b0, x} + {1'b0, off_eff};
      x_eff = {1'b0, x};
      if (mode_eff == MODE_SCROLL) begin
         x_eff = x_sum;
         if (x_sum >= (X_W+1)'(H_ACTIVE))
            x_eff = x_sum - (X_W+1)'(H_ACTIVE);
      end
   end

   // Bar indices via threshold comparators; the last bar absorbs any overshoot.
   always_comb begin
      bx_d = 3'd0;
      by_d = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (x_eff >= (X_W+1)'(k * BAR_W))
            bx_d = 3'(k);
         if (y >= Y_W'(k * BAR_H))
            by_d = 3'(k);
      end
   end

   always_comb begin
      blank_d = (x >= X_W'(H_ACTIVE)) || (y >= Y_W'(V_ACTIVE));
      chk_d   = x[CHK_LOG2] ^ y[CHK_LOG2];
      x_shr   = x >> GRAD_SHIFT;
      grey_d  = x_shr[BPC-1:0];
      if (x_shr > X_W'(GREY_MAX))
         grey_d = BPC'(GREY_MAX);
   end

   // Frame-level state: mode latch, frame counter and scroll offset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_active <= MODE_GRID;
         frame_cnt   <= '0;
         offset      <= '0;
      end else if (frame_start) begin
         mode_active <= mode;
         frame_cnt   <= frame_cnt + 1'b1;
         if (mode == MODE_SCROLL)
            offset <= off_next;
      end
   end

   logic           s1_blank;
   logic           s1_chk;
   logic [2:0]     s1_bx;
   logic [2:0]     s1_by;
   logic [BPC-1:0] s1_grey;
   logic [1:0]     s1_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_blank <= 1'b0;
         s1_chk   <= 1'b0;
         s1_bx    <= 3'd0;
         s1_by    <= 3'd0;
         s1_grey  <= '0;
         s1_mode  <= MODE_GRID;
      end else begin
         s1_blank <= blank_d;
         s1_chk   <= chk_d;
         s1_bx    <= bx_d;
         s1_by    <= by_d;
         s1_grey  <= grey_d;
         s1_mode  <= mode_eff;
      end
   end

   logic [2:0]    pbx;
   logic [2:0]    pby;
   logic [CW-1:0] color_d;

   always_comb begin
      pbx     = bar_bits(s1_bx);
      pby     = bar_bits(s1_by);
      color_d = '0;
      if (!s1_blank) begin
         for (int c = 0; c < 3; c++) begin
            case (s1_mode)
               MODE_CHECK: color_d[c*BPC +: BPC] = {BPC{s1_chk}};
               MODE_RAMP:  color_d[c*BPC +: BPC] = s1_grey;
               default:    color_d[c*BPC + BPC - 2 +: 2] = {pby[c], pbx[c]};
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         color <= '0;
      else
         color <= color_d;
   end

endmodule
